// File: rtl/store_buffer_pkg.sv
// Shared widths, default geometry and the store entry record for the store buffer.
// The entry record is the unit moved between the CPU, the FIFO and the data memory.
package store_buffer_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int SB_DEPTH    = 4;
  localparam int SB_IDX_BITS = 5;
  localparam int COUNT_W     = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side and memory-side signals of the store buffer; the slave modport is the buffer,
// the master modport is the CPU/memory environment around it.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_wdata;
  logic               cpu_write_en;
  logic               cpu_read_en;
  logic [DATA_W-1:0]  cpu_rdata;
  logic               cpu_stall;
  logic [ADDR_W-1:0]  mem_access_addr;
  logic [DATA_W-1:0]  mem_in;
  logic               mem_write_en;
  logic               mem_read_en;
  logic [DATA_W-1:0]  mem_out;
  logic               sb_empty;
  logic [COUNT_W-1:0] sb_count;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_write_en, cpu_read_en, mem_out,
    output cpu_rdata, cpu_stall, mem_access_addr, mem_in, mem_write_en, mem_read_en,
           sb_empty, sb_count
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_write_en, cpu_read_en, mem_out,
    input  cpu_rdata, cpu_stall, mem_access_addr, mem_in, mem_write_en, mem_read_en,
           sb_empty, sb_count
  );

endinterface

// File: rtl/store_buffer_fifo.sv
// Circular entry storage with head/tail pointers and occupancy; push lands on the edge.
// Push when full and pop when empty are ignored, so the count stays within 0..DEPTH.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  sb_entry_t                  push_entry,
  input  logic                       pop,
  output sb_entry_t                  entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [COUNT_W-1:0]         count
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [COUNT_W-1:0] count_q;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && (count_q != COUNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= push_entry;
  end

  assign entries = mem_q;
  assign rd_ptr  = rd_ptr_q;
  assign count   = count_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between CPU and single-port data memory: stores queue, loads forward or read through.
// Zero-latency load path; a store against a full buffer stalls while the head keeps draining.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH    = SB_DEPTH,
  parameter int IDX_BITS = SB_IDX_BITS
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  sb
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t          entries [DEPTH];
  sb_entry_t          head;
  sb_entry_t          new_entry;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               full;
  logic               is_store;
  logic               is_load;
  logic               push;
  logic               hit;
  logic [DATA_W-1:0]  hit_data;
  logic               load_miss;
  logic               drain;

  assign full      = (count == COUNT_W'(DEPTH));
  assign is_store  = sb.cpu_write_en;
  assign is_load   = sb.cpu_read_en && !sb.cpu_write_en;
  assign push      = is_store && !full && !reset;
  assign new_entry = '{addr: sb.cpu_addr, data: sb.cpu_wdata};
  assign head      = entries[rd_ptr];

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((COUNT_W'(k) < count) &&
          (entries[idx].addr[IDX_BITS-1:0] == sb.cpu_addr[IDX_BITS-1:0])) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

  assign load_miss = is_load && !hit;
  // Pending stores are dropped, never written, while reset is held.
  assign drain     = !reset && !load_miss && (count != '0);

  always_comb begin
    sb.cpu_rdata       = '0;
    sb.mem_read_en     = 1'b0;
    sb.mem_write_en    = 1'b0;
    sb.mem_access_addr = '0;
    sb.mem_in          = '0;
    if (load_miss) begin
      sb.mem_read_en     = 1'b1;
      sb.mem_access_addr = sb.cpu_addr;
      sb.cpu_rdata       = sb.mem_out;
    end else if (drain) begin
      sb.mem_write_en    = 1'b1;
      sb.mem_access_addr = head.addr;
      sb.mem_in          = head.data;
    end
    if (is_load && hit) sb.cpu_rdata = hit_data;
  end

  assign sb.cpu_stall = is_store && full && !reset;
  assign sb.sb_empty  = (count == '0);
  assign sb.sb_count  = count;

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (new_entry),
    .pop        (drain),
    .entries    (entries),
    .rd_ptr     (rd_ptr),
    .count      (count)
  );

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of queued store entries (power of two, 2..8).
REQ-002 Parameter IDX_BITS, default 5, address bits that select a data-memory word; higher bits are ignored for matching.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_addr  input  16  CPU load/store address.
REQ-006 cpu_wdata  input  16  CPU store data.
REQ-007 cpu_write_en  input  1  CPU store request.
REQ-008 cpu_read_en  input  1  CPU load request.
REQ-009 cpu_rdata  output  16  load result, combinational.
REQ-010 cpu_stall  output  1  store not accepted this cycle; CPU holds request.
REQ-011 mem_access_addr  output  16  data-memory address.
REQ-012 mem_in  output  16  data-memory write data.
REQ-013 mem_write_en  output  1  data-memory write strobe.
REQ-014 mem_read_en  output  1  data-memory read enable.
REQ-015 mem_out  input  16  data-memory combinational read data.
REQ-016 sb_empty  output  1  high when no stores are pending.
REQ-017 sb_count  output  4  number of pending entries, 0..DEPTH.

Function
REQ-018 The block SHALL be a FIFO of (addr, data) store entries between the CPU and the single-port data memory.
REQ-019 Store with count<DEPTH SHALL enqueue at tail on the edge; cpu_stall=0.
REQ-020 Store with count==DEPTH SHALL assert cpu_stall combinationally, with no enqueue that cycle.
REQ-021 Load SHALL compare cpu_addr[IDX_BITS-1:0] against every valid entry; on a hit cpu_rdata SHALL equal the youngest matching entry's data, mem_read_en=0.
REQ-022 Load miss SHALL drive mem_read_en=1, mem_access_addr=cpu_addr, cpu_rdata=mem_out in the same cycle (zero latency), and suppress draining that cycle.
REQ-023 In any cycle without a load miss and count>0, the block SHALL drive mem_write_en=1 with the head entry's addr/data and pop the head on the edge.
REQ-024 Drain and enqueue in the same cycle SHALL both occur; count is unchanged.
REQ-025 When full, a store SHALL stall and a drain SHALL proceed in the same cycle if no load miss; the store is accepted the next cycle.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-027 cpu_write_en and cpu_read_en both high is illegal; the store SHALL take priority, cpu_rdata=0, no read issued.
REQ-028 Idle cycles SHALL drive cpu_rdata=0, mem_read_en=0, mem_write_en=0, mem_access_addr=0, mem_in=0.
REQ-029 A load hit SHALL not block draining that cycle.

Reset
REQ-030 Reset SHALL clear pointers and count; sb_empty=1, sb_count=0, cpu_stall=0, all memory strobes 0.
REQ-031 Reset mid-operation SHALL discard all pending stores without writing them to memory; entry storage need not be cleared.

Structure
REQ-032 A shared package SHALL hold data width 16, address width 16, DEPTH and IDX_BITS defaults, and the entry record type.
REQ-033 Entry storage, pointers and count SHALL live in one sub-module, store_buffer_fifo; match/forward and memory-port muxing stay at top level.

Verification
REQ-034 After reset, store 0x1234 to addr 3 -> sb_count=1 next cycle; following idle cycle mem_write_en=1, addr 3, data 0x1234; sb_empty=1 after.
REQ-035 Store 0xAAAA then 0xBBBB to addr 5 back-to-back, then load addr 5 -> cpu_rdata=0xBBBB, mem_read_en=0.
REQ-036 Load addr 0x0025 with pending store to addr 5 -> hit (low 5 bits match), forwarded data returned.
REQ-037 Hold loads to unmatched addr 9 while 4 stores pending, then store again -> cpu_stall=1, no mem_write_en during loads; after loads stop, one drain per cycle and the stalled store is accepted next cycle.
REQ-038 Four stores pending, assert reset one cycle -> sb_count=0, no further mem_write_en, memory contents unchanged.
REQ-039 cpu_write_en and cpu_read_en both high -> store enqueued, cpu_rdata=0, mem_read_en=0.
